// File: rtl/clut_cache_if.sv
// VRAM fetch port of the CLUT cache: the request descriptor goes out and the word stream comes back.
// The cache uses the master modport and the VRAM arbiter uses the slave modport.
interface clut_cache_if;
  logic        memReq;
  logic [9:0]  memX;
  logic [8:0]  memY;
  logic [7:0]  memWords;
  logic        memAck;
  logic        memDataValid;
  logic [31:0] memData;

  modport master (
    output memReq, memX, memY, memWords,
    input  memAck, memDataValid, memData
  );

  modport slave (
    input  memReq, memX, memY, memWords,
    output memAck, memDataValid, memData
  );
endinterface

// File: rtl/clut_cache.sv
// Palette (CLUT) cache: a 256 x 16 palette with two read ports, refilled from VRAM on a tag miss.
// The palette is stored as 128 x 32 so that one write per beat stores both the even and the odd entry.
module clut_cache (
  input  logic        clk,
  input  logic        rst,
  input  logic        clutLoadReq,
  input  logic [5:0]  clutX,
  input  logic [8:0]  clutY,
  input  logic        clutIs8Bit,
  output logic        busy,
  clut_cache_if.master mem,
  input  logic        lookupValidA,
  input  logic [7:0]  indexLookupA,
  input  logic        lookupValidB,
  input  logic [7:0]  indexLookupB,
  output logic [15:0] ClutValueA,
  output logic [15:0] ClutValueB
);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, RECV = 2'd2} stateT;

  stateT       state;
  logic        tagValid;
  logic        tag8;
  logic [5:0]  tagX;
  logic [8:0]  tagY;
  logic        lat8;
  logic [5:0]  latX;
  logic [8:0]  latY;
  logic [6:0]  wordCnt;

  logic [31:0] ramMem [128];

  logic        hit;
  logic        ramWe;
  logic        lastBeat;
  logic [7:0]  fetchWords;
  logic [31:0] wordA;
  logic [31:0] wordB;

  // Tag compare, fetch length, last-beat detect and read-word selection
  always_comb begin
    hit        = tagValid && (tagX == clutX) && (tagY == clutY) && (tag8 || !clutIs8Bit);
    fetchWords = lat8 ? 8'd128 : 8'd8;
    lastBeat   = ({1'b0, wordCnt} == (fetchWords - 8'd1));
    ramWe      = !rst && (state == RECV) && mem.memDataValid;
    wordA      = ramMem[indexLookupA[7:1]];
    wordB      = ramMem[indexLookupB[7:1]];
  end

  assign mem.memX     = {latX, 4'b0000};
  assign mem.memY     = latY;
  assign mem.memWords = fetchWords;

  // Palette write port; the contents survive reset
  always_ff @(posedge clk) begin
    if (ramWe) begin
      ramMem[wordCnt] <= mem.memData;
    end
  end

  // Two independent read ports; each output holds its value while its lookup is idle
  always_ff @(posedge clk) begin
    if (rst) begin
      ClutValueA <= 16'd0;
      ClutValueB <= 16'd0;
    end else begin
      if (lookupValidA) begin
        ClutValueA <= indexLookupA[0] ? wordA[31:16] : wordA[15:0];
      end
      if (lookupValidB) begin
        ClutValueB <= indexLookupB[0] ? wordB[31:16] : wordB[15:0];
      end
    end
  end

  // Fetch controller: tag check in IDLE, request handshake, then beat reception
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      mem.memReq <= 1'b0;
      wordCnt    <= 7'd0;
      tagValid   <= 1'b0;
      tag8       <= 1'b0;
      tagX       <= 6'd0;
      tagY       <= 9'd0;
      lat8       <= 1'b0;
      latX       <= 6'd0;
      latY       <= 9'd0;
    end else begin
      case (state)
        IDLE: begin
          if (clutLoadReq && !hit) begin
            latX       <= clutX;
            latY       <= clutY;
            lat8       <= clutIs8Bit;
            tagValid   <= 1'b0;
            busy       <= 1'b1;
            mem.memReq <= 1'b1;
            state      <= REQ;
          end
        end
        REQ: begin
          if (mem.memAck) begin
            mem.memReq <= 1'b0;
            wordCnt    <= 7'd0;
            state      <= RECV;
          end
        end
        RECV: begin
          if (mem.memDataValid) begin
            wordCnt <= wordCnt + 7'd1;
            if (lastBeat) begin
              tagValid <= 1'b1;
              tagX     <= latX;
              tagY     <= latY;
              tag8     <= lat8;
              busy     <= 1'b0;
              state    <= IDLE;
            end
          end
        end
        default: begin
          state      <= IDLE;
          busy       <= 1'b0;
          mem.memReq <= 1'b0;
        end
      endcase
    end
  end

endmodule
